// File: rtl/if_stage.sv
// if_stage: RISC-V instruction fetch with PC, imem request/ack, IF/ID register and one-entry skid buffer.
// Ports: i_clk/i_rst clock and sync reset; i_PCSrc/i_branch_target MEM-stage redirect;
// i_stall holds IF/ID; o_imem_req/o_imem_addr/i_imem_ack/i_imem_rdata fetch handshake;
// o_pc/o_pc_plus4/o_instr/o_valid IF/ID entry.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_PCSrc,
  input  logic [31:0] i_branch_target,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_instr,
  output logic        o_valid
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_KILL, S_FULL} state_t;
  state_t state_q;
  logic [31:0] pc_q, redir_pc_q, skid_instr_q, tgt;
  assign tgt = {i_branch_target[31:2], 2'b00};
  assign o_imem_req = (state_q == S_REQ) || (state_q == S_KILL);
  assign o_imem_addr = pc_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      redir_pc_q <= '0;
      skid_instr_q <= 32'h0000_0013;
      o_pc <= '0;
      o_pc_plus4 <= 32'd4;
      o_instr <= 32'h0000_0013;
      o_valid <= 1'b0;
    end else if (i_PCSrc) begin
      o_valid <= 1'b0;
      // an unacked request must finish at its own address, so park the target
      if (o_imem_req && !i_imem_ack) begin
        redir_pc_q <= tgt;
        state_q <= S_KILL;
      end else begin
        pc_q <= tgt;
        state_q <= S_REQ;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          o_valid <= 1'b0;
        end
        S_REQ: begin
          if (i_imem_ack && !i_stall) begin
            o_pc <= pc_q;
            o_pc_plus4 <= pc_q + 32'd4;
            o_instr <= i_imem_rdata;
            o_valid <= 1'b1;
            pc_q <= pc_q + 32'd4;
          end else if (i_imem_ack) begin
            skid_instr_q <= i_imem_rdata;
            state_q <= S_FULL;
          end else if (!i_stall) begin
            o_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (!i_stall) begin
            o_pc <= pc_q;
            o_pc_plus4 <= pc_q + 32'd4;
            o_instr <= skid_instr_q;
            o_valid <= 1'b1;
            pc_q <= pc_q + 32'd4;
            state_q <= S_REQ;
          end
        end
        default: begin
          o_valid <= 1'b0;
          if (i_imem_ack) begin
            pc_q <= redir_pc_q;
            state_q <= S_REQ;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed stimulus with literal checks plus a program-order scoreboard for if_stage.
module tb_if_stage;
  logic clk = 1'b0, rst = 1'b1, pcsrc = 1'b0, stall = 1'b0, ack = 1'b0;
  logic [31:0] tgt = '0;
  logic req, valid;
  logic [31:0] addr, rdata, pc, pc4, instr;
  int npass = 0, ntot = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction
  assign rdata = mem(addr);
  if_stage #(.RESET_PC(32'h100)) dut (
    .i_clk(clk), .i_rst(rst), .i_PCSrc(pcsrc), .i_branch_target(tgt), .i_stall(stall),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack), .i_imem_rdata(rdata),
    .o_pc(pc), .o_pc_plus4(pc4), .o_instr(instr), .o_valid(valid)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endtask
  task automatic step(input logic p, input logic [31:0] t, input logic s, input logic a);
    pcsrc = p;
    tgt = t;
    stall = s;
    ack = a;
    @(posedge clk);
    #1;
  endtask
  logic p_ok = 1'b0, p_rst, p_pcsrc, p_stall, p_req, p_ack, p_valid;
  logic [31:0] p_tgt, p_addr, p_pc, p_instr, exp_pc;
  always @(negedge clk) begin
    if (p_ok && !p_rst) begin
      if (p_pcsrc) begin
        chk("redir_squash", 32'(valid), 32'd0);
        exp_pc = p_tgt & ~32'h3;
      end else if (p_stall) begin
        chk("hold_valid", 32'(valid), 32'(p_valid));
        chk("hold_pc", pc, p_pc);
        chk("hold_instr", instr, p_instr);
      end else if (valid) begin
        chk("seq_pc", pc, exp_pc);
        chk("seq_instr", instr, mem(exp_pc));
        chk("seq_pc4", pc4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end
      if (p_req && !p_ack) begin
        chk("req_held", 32'(req), 32'd1);
        chk("addr_held", addr, p_addr);
      end
    end
    if (p_rst) exp_pc = 32'h100;
    p_ok = 1'b1;
    p_rst = rst;
    p_pcsrc = pcsrc;
    p_stall = stall;
    p_req = req;
    p_ack = ack;
    p_valid = valid;
    p_tgt = tgt;
    p_addr = addr;
    p_pc = pc;
    p_instr = instr;
  end
  initial begin
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, 32'h100);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc4, 32'h4);
    chk("rst_instr", instr, 32'h13);
    chk("rst_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    step(0, 0, 0, 1);
    chk("first_req", 32'(req), 32'd1);
    chk("first_addr", addr, 32'h100);
    chk("first_valid", 32'(valid), 32'd0);
    step(0, 0, 0, 1);
    chk("d100_pc", pc, 32'h100);
    chk("d100_instr", instr, 32'hDEAD_0113);
    chk("d100_pc4", pc4, 32'h104);
    chk("d100_addr", addr, 32'h104);
    step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", 32'(req), 32'd0);
      chk("stall_pc", pc, 32'h100);
      step(0, 0, 1, 0);
    end
    chk("stall_req", 32'(req), 32'd0);
    step(0, 0, 0, 0);
    chk("skid_pc", pc, 32'h104);
    chk("skid_instr", instr, 32'hDEAD_0117);
    chk("skid_valid", 32'(valid), 32'd1);
    chk("skid_next_addr", addr, 32'h108);
    step(0, 0, 0, 1);
    chk("d108_pc", pc, 32'h108);
    step(1, 32'h200, 0, 1);
    chk("br_ack_valid", 32'(valid), 32'd0);
    chk("br_ack_addr", addr, 32'h200);
    step(0, 0, 0, 1);
    chk("br_ack_pc", pc, 32'h200);
    chk("br_ack_v", 32'(valid), 32'd1);
    step(1, 32'h40, 0, 0);
    chk("kill_addr0", addr, 32'h204);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("kill_addr2", addr, 32'h204);
    chk("kill_valid", 32'(valid), 32'd0);
    step(0, 0, 0, 1);
    chk("kill_end_addr", addr, 32'h40);
    chk("kill_end_valid", 32'(valid), 32'd0);
    step(0, 0, 0, 1);
    chk("d40_pc", pc, 32'h40);
    step(0, 0, 1, 1);
    step(1, 32'h300, 1, 0);
    chk("full_br_valid", 32'(valid), 32'd0);
    chk("full_br_addr", addr, 32'h300);
    chk("full_br_req", 32'(req), 32'd1);
    step(0, 0, 0, 1);
    chk("d300_instr", instr, 32'hDEAD_0313);
    step(1, 32'hFFFF_FFFC, 0, 1);
    chk("wrap_tgt_addr", addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("wrap_addr", addr, 32'h0);
    chk("wrap_pc4", pc4, 32'h0);
    step(1, 32'h203, 0, 1);
    chk("align_addr", addr, 32'h200);
    step(0, 0, 0, 1);
    step(1, 32'h40, 0, 0);
    step(1, 32'h80, 0, 0);
    chk("kill2_addr", addr, 32'h204);
    step(0, 0, 0, 1);
    chk("newest_addr", addr, 32'h80);
    step(0, 0, 0, 1);
    chk("d80_pc", pc, 32'h80);
    step(0, 0, 0, 0);
    chk("bubble_valid", 32'(valid), 32'd0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    chk("d84_pc", pc, 32'h84);
    rst = 1'b1;
    step(0, 0, 0, 0);
    chk("midrst_addr", addr, 32'h100);
    chk("midrst_req", 32'(req), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("post_rst_pc", pc, 32'h100);
    step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
